// File: rtl/dbus_sram_ctrl_if.sv
// CPU data-bus interface between the core's data port and the SRAM controller.
// master: the CPU side, drives the request and samples rddata/stall.
// slave : the controller side, samples the request and drives rddata/stall.
//   address    byte address
//   byteenable write byte lanes, bit0 = data[7:0]
//   read/write request strobes, held while stall=1
//   wrdata     write data, held with the request
//   rddata     read data register
//   stall      1 = request not yet complete
interface dbus_sram_ctrl_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] wrdata;
  logic [31:0] rddata;
  logic        stall;

  modport master (
    output address, byteenable, read, write, wrdata,
    input  rddata, stall
  );

  modport slave (
    input  address, byteenable, read, write, wrdata,
    output rddata, stall
  );
endinterface

// File: rtl/dbus_sram_ctrl.sv
// Data-bus slave that turns single-word CPU requests into multi-cycle
// accesses to one 32-bit async SRAM bank built from two 16-bit devices.
// The CPU is held with dbus.stall until each access completes.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   dbus          CPU data bus (slave modport)
//   sram_addr     word address to both devices
//   sram_data_o   write data to the pads, sram_data_oe enables the driver
//   sram_data_i   read data from the pads
//   sram_ce_n/oe_n/we_n  active-low chip, output and write enables
//   sram_be_n     active-low lane enables (LB_n/UB_n of both devices)
// Every pad output comes straight from a flop: the next-state logic computes
// the value for the state being entered and it is registered on the same
// edge as the state, so pads never glitch.
module dbus_sram_ctrl #(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_CYCLES = 2   // strobe width in cycles, 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  dbus_sram_ctrl_if.slave       dbus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_o,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  typedef struct packed {
    logic                  ce_n;
    logic                  oe_n;
    logic                  we_n;
    logic                  data_oe;
    logic [3:0]            be_n;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } pads_t;

  state_t      state, state_d;
  logic [3:0]  wcnt, wcnt_d;
  pads_t       pads_q, pads_d;
  logic [31:0] rddata_q;
  logic        rd_cap;
  logic        stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wcnt           <= '0;
      rddata_q       <= '0;
      pads_q.ce_n    <= 1'b1;
      pads_q.oe_n    <= 1'b1;
      pads_q.we_n    <= 1'b1;
      pads_q.data_oe <= 1'b0;
      pads_q.be_n    <= 4'hF;
      pads_q.addr    <= '0;
      pads_q.data    <= '0;
    end else begin
      state  <= state_d;
      wcnt   <= wcnt_d;
      pads_q <= pads_d;
      if (rd_cap) rddata_q <= sram_data_i;
    end
  end

  always_comb begin
    state_d        = state;
    wcnt_d         = wcnt;
    rd_cap         = 1'b0;
    stall          = 1'b0;
    // address, data and lane enables hold unless a state below changes them;
    // the strobes default to inactive
    pads_d         = pads_q;
    pads_d.ce_n    = 1'b1;
    pads_d.oe_n    = 1'b1;
    pads_d.we_n    = 1'b1;
    pads_d.data_oe = 1'b0;
    unique case (state)
      IDLE: begin
        stall = dbus.read | dbus.write;
        if (dbus.write) begin
          // write wins over a simultaneous read
          state_d        = WR_SETUP;
          pads_d.addr    = dbus.address[ADDR_WIDTH+1:2];
          pads_d.data    = dbus.wrdata;
          pads_d.be_n    = ~dbus.byteenable;
          pads_d.ce_n    = 1'b0;
          pads_d.data_oe = 1'b1;
        end else if (dbus.read) begin
          state_d     = RD;
          wcnt_d      = WAIT_INIT;
          pads_d.addr = dbus.address[ADDR_WIDTH+1:2];
          pads_d.be_n = 4'h0;
          pads_d.ce_n = 1'b0;
          pads_d.oe_n = 1'b0;
        end
      end
      RD: begin
        stall  = 1'b1;
        wcnt_d = wcnt - 4'd1;
        if (wcnt == 4'd1) begin
          rd_cap      = 1'b1;
          state_d     = DONE;
          pads_d.be_n = 4'hF;
        end else begin
          pads_d.ce_n = 1'b0;
          pads_d.oe_n = 1'b0;
        end
      end
      WR_SETUP: begin
        stall          = 1'b1;
        wcnt_d         = WAIT_INIT;
        state_d        = WR_PULSE;
        pads_d.ce_n    = 1'b0;
        pads_d.data_oe = 1'b1;
        pads_d.we_n    = 1'b0;
      end
      WR_PULSE: begin
        stall          = 1'b1;
        wcnt_d         = wcnt - 4'd1;
        pads_d.ce_n    = 1'b0;
        pads_d.data_oe = 1'b1;
        // WE rises into WR_HOLD with address and data still driven
        if (wcnt == 4'd1) state_d = WR_HOLD;
        else              pads_d.we_n = 1'b0;
      end
      WR_HOLD: begin
        stall       = 1'b1;
        state_d     = DONE;
        pads_d.be_n = 4'hF;
      end
      DONE: begin
        // request lines still belong to the retiring access
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbus.stall   = stall;
  assign dbus.rddata  = rddata_q;
  assign sram_addr    = pads_q.addr;
  assign sram_data_o  = pads_q.data;
  assign sram_data_oe = pads_q.data_oe;
  assign sram_ce_n    = pads_q.ce_n;
  assign sram_oe_n    = pads_q.oe_n;
  assign sram_we_n    = pads_q.we_n;
  assign sram_be_n    = pads_q.be_n;
endmodule

// File: tb/tb_dbus_sram_ctrl.sv
// Directed bench for dbus_sram_ctrl. u0 runs with WAIT_CYCLES=2 against a
// byte-lane SRAM model; u1 runs with WAIT_CYCLES=1 against a read-only
// pattern memory for the back-to-back read sequence. One request channel is
// steered to either DUT with sel.
module tb_dbus_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // request channel
  logic        sel  = 1'b0;
  logic        rd_r = 1'b0;
  logic        wr_r = 1'b0;
  logic [31:0] a_r  = '0;
  logic [31:0] d_r  = '0;
  logic [3:0]  be_r = '0;

  dbus_sram_ctrl_if bus0();
  dbus_sram_ctrl_if bus1();

  assign bus0.address    = a_r;
  assign bus0.wrdata     = d_r;
  assign bus0.byteenable = be_r;
  assign bus0.read       = rd_r & ~sel;
  assign bus0.write      = wr_r & ~sel;
  assign bus1.address    = a_r;
  assign bus1.wrdata     = d_r;
  assign bus1.byteenable = be_r;
  assign bus1.read       = rd_r & sel;
  assign bus1.write      = wr_r & sel;

  logic [19:0] addr0, addr1;
  logic [31:0] dout0, dout1, din0, din1;
  logic        doe0, doe1, ce_n0, ce_n1, oe_n0, oe_n1, we_n0, we_n1;
  logic [3:0]  be_n0, be_n1;

  dbus_sram_ctrl #(.ADDR_WIDTH(20), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .dbus(bus0),
    .sram_addr(addr0), .sram_data_o(dout0), .sram_data_i(din0),
    .sram_data_oe(doe0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0),
    .sram_we_n(we_n0), .sram_be_n(be_n0)
  );

  dbus_sram_ctrl #(.ADDR_WIDTH(20), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .dbus(bus1),
    .sram_addr(addr1), .sram_data_o(dout1), .sram_data_i(din1),
    .sram_data_oe(doe1), .sram_ce_n(ce_n1), .sram_oe_n(oe_n1),
    .sram_we_n(we_n1), .sram_be_n(be_n1)
  );

  // SRAM model for u0: a write commits when WE rises while the chip is
  // still selected and driven; a reset abort drops CE with WE, so no commit.
  logic [31:0] mem0 [256];
  int          wr_cnt0  = 0;
  int          viol0    = 0;
  logic        we_prev0 = 1'b1;
  logic [19:0] a_prev0  = '0;
  logic [31:0] d_prev0  = '0;

  always @(negedge clk) begin
    if (!we_prev0 && we_n0 && !ce_n0 && doe0) begin
      for (int b = 0; b < 4; b++)
        if (!be_n0[b]) mem0[addr0[7:0]][8*b +: 8] <= dout0[8*b +: 8];
      wr_cnt0 <= wr_cnt0 + 1;
    end
    if (!rst && (!we_n0 || !we_prev0) && (addr0 != a_prev0 || dout0 != d_prev0))
      viol0 <= viol0 + 1;
    we_prev0 <= we_n0;
    a_prev0  <= addr0;
    d_prev0  <= dout0;
  end

  assign din0 = (!ce_n0 && !oe_n0) ? mem0[addr0[7:0]] : 32'h0;

  function automatic logic [31:0] pat(input logic [19:0] w);
    return {w[15:0] ^ 16'h5A5A, w[15:0]};
  endfunction

  assign din1 = (!ce_n1 && !oe_n1) ? pat(addr1) : 32'h0;

  // views of the selected DUT
  logic        m_stall, m_we_n, m_oe_n, m_doe;
  logic [3:0]  m_be_n;
  logic [19:0] m_addr;
  logic [31:0] m_rddata;
  assign m_stall  = sel ? bus1.stall  : bus0.stall;
  assign m_we_n   = sel ? we_n1       : we_n0;
  assign m_oe_n   = sel ? oe_n1       : oe_n0;
  assign m_doe    = sel ? doe1        : doe0;
  assign m_be_n   = sel ? be_n1       : be_n0;
  assign m_addr   = sel ? addr1       : addr0;
  assign m_rddata = sel ? bus1.rddata : bus0.rddata;

  // One access, started from a negedge in IDLE; returns at the negedge of
  // the IDLE cycle after DONE with the request dropped.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int stalls, output int we_low, output int doe_cnt,
                        output int oe_low, output logic [19:0] p_addr,
                        output logic [3:0] p_be_n, output logic [31:0] rdat);
    logic done;
    rd_r = rd; wr_r = wr; a_r = a; d_r = d; be_r = be;
    stalls = 0; we_low = 0; doe_cnt = 0; oe_low = 0;
    p_addr = '0; p_be_n = '0; rdat = '0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (!m_we_n) begin
        if (we_low == 0) begin p_addr = m_addr; p_be_n = m_be_n; end
        we_low++;
      end
      if (m_doe)   doe_cnt++;
      if (!m_oe_n) oe_low++;
      if (m_stall) begin
        stalls++;
        @(negedge clk);
      end else begin
        rdat = m_rddata;
        done = 1'b1;
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    rd_r = 1'b0; wr_r = 1'b0;
    @(negedge clk);
  endtask

  int          st, wl, dc, ol, wc;
  logic [19:0] pa;
  logic [3:0]  pb;
  logic [31:0] rv, last_rd;

  initial begin
    // reset, then 20 idle cycles
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("rst_ce_n",  32'(ce_n0),       32'd1);
    chk("rst_oe_n",  32'(oe_n0),       32'd1);
    chk("rst_we_n",  32'(we_n0),       32'd1);
    chk("rst_be_n",  32'(be_n0),       32'hF);
    chk("rst_doe",   32'(doe0),        32'd0);
    chk("rst_stall", 32'(bus0.stall),  32'd0);
    chk("rst_rdata", bus0.rddata,      32'd0);
    chk("rst_addr",  32'(addr0),       32'd0);
    chk("rst_dout",  dout0,            32'd0);

    // full-word write, bit 31 of the address is outside the SRAM range
    access(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, st, wl, dc, ol, pa, pb, rv);
    chk("wr_stall",   32'(st), 32'd5);
    chk("wr_we_low",  32'(wl), 32'd2);
    chk("wr_doe_cyc", 32'(dc), 32'd4);
    chk("wr_addr",    32'(pa), 32'h4);
    chk("wr_commit",  mem0[4], 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, st, wl, dc, ol, pa, pb, rv);
    chk("rd_stall",  32'(st), 32'd3);
    chk("rd_oe_low", 32'(ol), 32'd2);
    chk("rd_data",   rv,      32'hDEAD_BEEF);

    // byte-lane write into a preloaded word
    access(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'hF, st, wl, dc, ol, pa, pb, rv);
    access(1'b0, 1'b1, 32'h40, 32'h0000_AB00, 4'b0010, st, wl, dc, ol, pa, pb, rv);
    chk("bw_be_n", 32'(pb), 32'b1101);
    access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, st, wl, dc, ol, pa, pb, rv);
    chk("bw_readback", rv, 32'h1122_AB44);

    // zero byteenable: full sequence, nothing changes
    access(1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, st, wl, dc, ol, pa, pb, rv);
    chk("be0_stall", 32'(st), 32'd5);
    chk("be0_be_n",  32'(pb), 32'hF);
    access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, st, wl, dc, ol, pa, pb, rv);
    chk("be0_readback", rv, 32'h1122_AB44);
    last_rd = rv;

    // read and write together: write only
    wc = wr_cnt0;
    access(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, st, wl, dc, ol, pa, pb, rv);
    chk("both_stall",  32'(st),         32'd5);
    chk("both_we_low", 32'(wl),         32'd2);
    chk("both_no_oe",  32'(ol),         32'd0);
    chk("both_pulses", 32'(wr_cnt0 - wc), 32'd1);
    chk("both_rdata",  bus0.rddata,     last_rd);
    chk("both_mem",    mem0[8],         32'hCAFE_F00D);

    // reset in the second WR_PULSE cycle
    wc = wr_cnt0;
    wr_r = 1'b1; a_r = 32'h30; d_r = 32'h5555_5555; be_r = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_in_pulse", 32'(we_n0), 32'd0);
    rst = 1'b1; wr_r = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_we_n",  32'(we_n0),      32'd1);
    chk("abort_doe",   32'(doe0),       32'd0);
    chk("abort_ce_n",  32'(ce_n0),      32'd1);
    chk("abort_stall", 32'(bus0.stall), 32'd0);
    chk("abort_rdata", bus0.rddata,     32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_wr", 32'(wr_cnt0 - wc), 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, st, wl, dc, ol, pa, pb, rv);
    chk("post_rd_stall", 32'(st), 32'd3);
    chk("post_rd_data",  rv,      32'hDEAD_BEEF);
    chk("we_window", 32'(viol0), 32'd0);

    // back-to-back reads on the WAIT_CYCLES=1 instance
    sel = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      access(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0, st, wl, dc, ol, pa, pb, rv);
      chk($sformatf("b2b_stall%0d", k), 32'(st), 32'd2);
      chk($sformatf("b2b_data%0d", k),  rv,      pat(20'h40 + 20'(k)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbus_sram_ctrl.md
Name: dbus_sram_ctrl

Overview:
- Data-bus slave that sits directly downstream of the CPU data port (dbus_*) and converts single-word requests into multi-cycle accesses to one 32-bit external async SRAM bank.
- The SRAM bank is built from two 16-bit devices.
- Holds the CPU with dbus_stall until each access completes, replacing the zero-wait behavioural RAM on real boards.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width; the controller uses dbus_address[ADDR_WIDTH+1:2].
- WAIT_CYCLES, 2, number of cycles the read OE or write WE strobe is held active; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dbus_address  in  32  byte address; bits [1:0] and bits above ADDR_WIDTH+1 are ignored.
- dbus_byteenable  in  4  byte lanes for a write; bit0 = data[7:0].
- dbus_read  in  1  read request; held by the CPU while dbus_stall=1.
- dbus_write  in  1  write request; held by the CPU while dbus_stall=1.
- dbus_wrdata  in  32  write data; held with the request.
- dbus_rddata  out  32  read data register.
- dbus_stall  out  1  1 = request not yet complete.
- sram_addr  out  ADDR_WIDTH  word address to both devices.
- sram_data_o  out  32  data driven to the SRAM.
- sram_data_i  in  32  data returned by the SRAM.
- sram_data_oe  out  1  pad tristate enable for sram_data_o.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_be_n  out  4  lane enables, active low; maps to LB_n/UB_n of the two devices.

Behaviour:
- Registered FSM with states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- A 4-bit wait counter wcnt controls the RD and WR_PULSE durations.
- Reset values:
  - state=IDLE, wcnt=0.
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_be_n=4'hF, sram_data_oe=0.
  - sram_addr=0, sram_data_o=0, dbus_rddata=0.
- Reset mid-access aborts the access immediately: the next cycle shows the reset values, no WE pulse is completed, and dbus_rddata is not updated.
- dbus_stall (combinational):
  - IDLE: stall = dbus_read|dbus_write.
  - RD, WR_*: stall = 1.
  - DONE: stall = 0.
- IDLE:
  - If dbus_write=1, latch address, wrdata and ~byteenable, then go to WR_SETUP.
  - Else if dbus_read=1, latch address, set be_n=0, wcnt=WAIT_CYCLES, then go to RD.
  - If both are asserted, the write wins and the read is dropped.
- RD:
  - Drives ce_n=0, oe_n=0, data_oe=0; wcnt decrements each cycle.
  - On the edge where wcnt==1, capture sram_data_i into dbus_rddata and go to DONE.
- WR_SETUP (1 cycle):
  - Drives ce_n=0, data_oe=1, we_n=1 (address/data setup).
  - Sets wcnt=WAIT_CYCLES and goes to WR_PULSE.
- WR_PULSE:
  - Drives we_n=0, data_oe=1; wcnt decrements.
  - When wcnt==1, go to WR_HOLD.
- WR_HOLD (1 cycle): drives we_n=1 while data_oe=1 and the address are held, then goes to DONE.
- DONE (1 cycle):
  - Drives ce_n=1, oe_n=1, data_oe=0, stall=0; the CPU retires the access on this edge.
  - Always returns to IDLE. Request lines sampled in DONE are ignored, because they belong to the retiring access.
- Latency, counted from the request in IDLE:
  - A read stalls for WAIT_CYCLES+1 cycles; the DONE cycle has stall=0 with valid dbus_rddata.
  - A write stalls for WAIT_CYCLES+3 cycles.
- Back-to-back accesses: the IDLE cycle after DONE accepts the next request, so there is one idle bus cycle between accesses.
- dbus_rddata holds its last captured value across writes and idle cycles.
- A write with byteenable=0 still runs the full sequence with be_n=4'hF, so no bytes change.
- All SRAM control outputs are registered (no glitches).
- WE low never overlaps a change of sram_addr or sram_data_o.

Test Plan:
- Reset then idle, 20 cycles with no requests -> ce_n=oe_n=we_n=1, be_n=F, data_oe=0, stall=0, rddata=0.
- WAIT_CYCLES=2: write addr 0x80000010, data 0xDEADBEEF, be=F -> stall high for 5 cycles; sram_addr=4; we_n low for exactly 2 cycles with data_oe=1 one cycle before and after; then read the same address -> stall 3 cycles, rddata=0xDEADBEEF in the DONE cycle.
- Byte write be=4'b0010, data 0x0000AB00, to a word preloaded with 0x11223344 -> be_n=4'b1101 during the pulse; readback=0x1122AB44.
- dbus_read and dbus_write both high for one request, addr 0x20 -> write sequence only, exactly one WE pulse, rddata unchanged.
- Assert rst during cycle 2 of WR_PULSE -> the next cycle shows we_n=1, data_oe=0, stall=0 with no request; the SRAM model records no completed write; the next read behaves normally.
- Back-to-back: 8 consecutive reads at increasing addresses with WAIT_CYCLES=1 -> each completes in 2 stalled cycles plus DONE, with one idle cycle between accesses and correct data for every address.
